cover_toggle_collector: RTL and testbench
=========================================

// Module: cover_toggle_collector
// PURPOSE
//  Parametrised coverage-point collector for a WIDTH-bit group of toggle/cover signals.
//  Samples the event vector and latches first hits in a sticky bitmap.
//  Serialises newly covered points onto a valid/ready index stream, one per cycle.
//  Used by the fuzz/formal harness and by synthesised FPGA builds.
//  Simulation DPI reporting is a side effect of the stream handshake.
// PARAMETERS
//  WIDTH        120  number of cover points in this group (>=1)
//  COVER_INDEX  0    global index of bit 0; out_index = COVER_INDEX + bit
//  IDX_W        32   width of out_index
//  MODE         0    0 = LEVEL (event = valid[i]); 1 = TOGGLE (event = valid[i] != prev[i])
//  CNT_W        $clog2(WIDTH+1)  width of covered_count (derived, not overridden)
// PORTS
//  gbl_clk        in   1      clock
//  reset          in   1      synchronous, active-low reset
//  valid          in   WIDTH  raw cover/toggle signals, sampled every enabled cycle
//  en             in   1      sample enable; en=0 -> no new events, stream keeps draining
//  clear          in   1      clear hit/pending bitmaps, counter and output register
//  out_valid      out  1      out_index holds a newly covered point
//  out_ready      in   1      consumer accepts out_index when out_valid & out_ready
//  out_index      out  IDX_W  global cover index being reported
//  covered_count  out  CNT_W  number of distinct points hit since reset/clear
//  all_covered    out  1      covered_count == WIDTH
//  pending        out  1      |pend | out_valid (reports still to drain)
// BEHAVIOUR
//  - Reset (reset==0 at edge): hit=0, pend=0, prev=0, prev_ok=0, out_valid=0, out_index=0,
//    covered_count=0; so all_covered=0 and pending=0.
//  - event[i]: MODE0 = valid[i]; MODE1 = prev_ok & (valid[i]^prev[i]).
//    On enabled cycles prev<=valid and prev_ok<=1.
//    The first enabled cycle after reset/clear never reports toggles.
//  - new = en ? event & ~hit : 0.
//  - Each edge: hit|=new; pend|=new; covered_count += popcount(new).
//    Count saturates naturally at WIDTH because a point is only ever new once.
//  - Output register load when !out_valid | out_ready:
//    - if pend!=0 (registered value), select lowest set bit k;
//      out_index<=COVER_INDEX+k, out_valid<=1, clear pend[k];
//    - otherwise out_valid<=0.
//  - out_valid/out_index are stable while out_valid & !out_ready.
//  - Latency: event sampled at edge N -> pend set at N; out_valid high after edge N+1.
//    Throughput is one index per cycle.
//  - Same-cycle new[k] and selection: selection uses pre-edge pend only.
//    A bit newly set this cycle is selectable next cycle; a pend bit is never lost or duplicated.
//  - Ordering: lowest index first among pending; points hit earlier may be overtaken.
//  - clear=1 (reset high) beats everything: hit, pend, prev_ok, count, out_valid <= 0.
//    Events in the clear cycle are discarded; an un-handshaked out_index is dropped.
//  - Reset mid-drain behaves exactly like clear plus prev<=0.
//  - Each out_index is emitted exactly once per reset/clear epoch.
//  - Sim only (`ifndef SYNTHESIS && `ifdef DIFFTEST):
//    DPI v_cover_toggle(out_index) on every out_valid & out_ready edge with reset high.
// STRUCTURE
//  - Shared package cover_pkg:
//    - cover_mode_e {COVER_LEVEL, COVER_TOGGLE}
//    - COVER_TOTAL constant
//    - DPI import declaration
//  - Sub-module cover_prio_enc #(WIDTH): combinational lowest-set-bit finder.
//    Outputs any, idx[$clog2(WIDTH)-1:0] and onehot (used to clear the pend bit).
//  - Popcount and all registers live in this module.
// TESTING
//  1. MODE0, WIDTH=8, out_ready=1; valid=8'h05 for 3 cycles -> indices C+0 then C+2 on
//     consecutive cycles, never repeated; covered_count=2.
//  2. MODE0, out_ready=0, valid=8'hFF one cycle -> out_valid held at C+0.
//     Raise ready -> C+0..C+7 in 8 cycles; all_covered=1; pending=0 after.
//  3. MODE1: valid 0->0x10 on the first enabled cycle -> no report.
//     Then 0x10->0x00 -> report C+4 once; a later toggle of bit 4 -> no report.
//  4. Mid-drain: pend=0xF0 with one index in flight; pulse clear with valid=0x01 that cycle.
//     Next cycle out_valid=0, count=0, and bit 0 is not recorded.
//     Re-hit 0x80 -> C+7 reported again.
//  5. Backpressure race: out_valid=1 (C+3), ready=0, new hit on bit 1 -> out_index stays C+3;
//     after accept, next is C+1.
//  6. en=0 with valid=0xFF -> no hits and count unchanged; draining of existing pend continues.

Source files
------------

// File: rtl/cover_pkg.sv
// cover_pkg
//   Shared definitions for the coverage collectors:
//     cover_mode_e   - event detection mode (level or toggle)
//     COVER_TOTAL    - default number of cover points per group
//     sel_width()    - width of a bit index into a WIDTH-bit vector (at least 1)
package cover_pkg;

    typedef enum logic {
        COVER_LEVEL  = 1'b0,
        COVER_TOGGLE = 1'b1
    } cover_mode_e;

    localparam int COVER_TOTAL = 120;

    // A single-bit vector still needs a one-bit index so port widths never collapse to zero.
    function automatic int sel_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/cover_prio_enc.sv
// cover_prio_enc
//   Combinational lowest-set-bit finder.
//   Ports:
//     vec    in   WIDTH   candidate bits
//     any    out  1       at least one bit of vec is set
//     idx    out  SEL_W   position of the lowest set bit (0 when none)
//     onehot out  WIDTH   one-hot mask of that bit (0 when none)
module cover_prio_enc
    import cover_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int SEL_W = sel_width(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic             any,
    output logic [SEL_W-1:0] idx,
    output logic [WIDTH-1:0] onehot
);

    // Scan from the top down so the last match written is the lowest set bit.
    always_comb begin
        any    = |vec;
        idx    = '0;
        onehot = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx       = SEL_W'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cover_toggle_collector.sv
// cover_toggle_collector
//   Latches first hits of a group of cover/toggle signals in a sticky bitmap and
//   serialises each newly covered point, lowest index first, onto a valid/ready
//   index stream at up to one index per cycle.
//   Ports:
//     gbl_clk        in   1      clock
//     reset          in   1      synchronous, active-low reset
//     valid          in   WIDTH  raw cover/toggle signals
//     en             in   1      sample enable (stream keeps draining when low)
//     clear          in   1      clear hit/pending state, counter and output register
//     out_valid      out  1      out_index holds a newly covered point
//     out_ready      in   1      consumer accepts out_index
//     out_index      out  IDX_W  global cover index (COVER_INDEX + bit)
//     covered_count  out  CNT_W  distinct points hit since reset/clear
//     all_covered    out  1      every point of the group has been hit
//     pending        out  1      reports still waiting to be drained
module cover_toggle_collector
    import cover_pkg::*;
#(
    parameter int          WIDTH       = COVER_TOTAL,
    parameter int          COVER_INDEX = 0,
    parameter int          IDX_W       = 32,
    parameter cover_mode_e MODE        = COVER_LEVEL,
    localparam int         CNT_W       = $clog2(WIDTH + 1)
) (
    input  logic             gbl_clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] valid,
    input  logic             en,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic [CNT_W-1:0] covered_count,
    output logic             all_covered,
    output logic             pending
);

    localparam int SEL_W = sel_width(WIDTH);

    logic [WIDTH-1:0] hit_q, hit_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             prev_ok_q, prev_ok_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_index_q, out_index_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [WIDTH-1:0] evt_vec;
    logic [WIDTH-1:0] new_vec;
    logic             sel_any;
    logic [SEL_W-1:0] sel_idx;
    logic [WIDTH-1:0] sel_onehot;
    logic             load;

    function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // Selection looks only at the registered pend bits, so a point that becomes
    // new this cycle waits one cycle before it can be chosen.
    cover_prio_enc #(.WIDTH(WIDTH)) u_prio_enc (
        .vec    (pend_q),
        .any    (sel_any),
        .idx    (sel_idx),
        .onehot (sel_onehot)
    );

    // Event detection, bitmap update and output register load.
    always_comb begin
        if (MODE == COVER_TOGGLE) begin
            evt_vec = prev_ok_q ? (valid ^ prev_q) : '0;
        end else begin
            evt_vec = valid;
        end
        new_vec = en ? (evt_vec & ~hit_q) : '0;
        load    = !out_valid_q || out_ready;

        hit_d       = hit_q | new_vec;
        pend_d      = pend_q | new_vec;
        count_d     = count_q + popcount(new_vec);
        prev_d      = en ? valid : prev_q;
        prev_ok_d   = en ? 1'b1 : prev_ok_q;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;

        if (load) begin
            if (sel_any) begin
                // A newly hit bit can never be the selected one: it was already in hit.
                pend_d      = (pend_q & ~sel_onehot) | new_vec;
                out_valid_d = 1'b1;
                out_index_d = IDX_W'(COVER_INDEX) + IDX_W'(sel_idx);
            end else begin
                out_valid_d = 1'b0;
            end
        end

        // Clear wins over everything; prev is kept but ignored until re-armed.
        if (clear) begin
            hit_d       = '0;
            pend_d      = '0;
            count_d     = '0;
            prev_ok_d   = 1'b0;
            out_valid_d = 1'b0;
            out_index_d = '0;
        end
    end

    always_ff @(posedge gbl_clk) begin
        if (!reset) begin
            hit_q       <= '0;
            pend_q      <= '0;
            prev_q      <= '0;
            prev_ok_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            count_q     <= '0;
        end else begin
            hit_q       <= hit_d;
            pend_q      <= pend_d;
            prev_q      <= prev_d;
            prev_ok_q   <= prev_ok_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            count_q     <= count_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_index     = out_index_q;
    assign covered_count = count_q;
    assign all_covered   = (count_q == CNT_W'(WIDTH));
    assign pending       = (|pend_q) || out_valid_q;

endmodule

// File: tb/tb_cover_toggle_collector.sv
// tb_cover_toggle_collector
//   Scoreboard bench for cover_toggle_collector. Two 8-bit instances with base
//   index 16: one in level mode, one in toggle mode. Directed stimulus pushes the
//   hand-computed index sequence into a per-instance queue; a monitor pops and
//   compares on every handshake.
module tb_cover_toggle_collector;
    import cover_pkg::*;

    localparam int W  = 8;
    localparam int C  = 16;
    localparam int CW = $clog2(W + 1);

    logic          gbl_clk = 1'b0;
    logic          reset;

    logic [W-1:0]  l_valid;
    logic          l_en, l_clear, l_ready;
    logic          l_out_valid, l_all, l_pending;
    logic [31:0]   l_out_index;
    logic [CW-1:0] l_count;

    logic [W-1:0]  t_valid;
    logic          t_en, t_clear, t_ready;
    logic          t_out_valid, t_all, t_pending;
    logic [31:0]   t_out_index;
    logic [CW-1:0] t_count;

    int            pass_cnt  = 0;
    int            check_cnt = 0;
    logic [31:0]   exp_l[$];
    logic [31:0]   exp_t[$];

    cover_toggle_collector #(
        .WIDTH(W), .COVER_INDEX(C), .IDX_W(32), .MODE(COVER_LEVEL)
    ) dut_l (
        .gbl_clk(gbl_clk), .reset(reset), .valid(l_valid), .en(l_en), .clear(l_clear),
        .out_valid(l_out_valid), .out_ready(l_ready), .out_index(l_out_index),
        .covered_count(l_count), .all_covered(l_all), .pending(l_pending)
    );

    cover_toggle_collector #(
        .WIDTH(W), .COVER_INDEX(C), .IDX_W(32), .MODE(COVER_TOGGLE)
    ) dut_t (
        .gbl_clk(gbl_clk), .reset(reset), .valid(t_valid), .en(t_en), .clear(t_clear),
        .out_valid(t_out_valid), .out_ready(t_ready), .out_index(t_out_index),
        .covered_count(t_count), .all_covered(t_all), .pending(t_pending)
    );

    always #5 gbl_clk = ~gbl_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] v, input logic e, input logic c, input logic r);
        l_valid = v;
        l_en    = e;
        l_clear = c;
        l_ready = r;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge gbl_clk);
        #1;
    endtask

    // Monitor: every accepted index must be the next one the stimulus predicted.
    always @(negedge gbl_clk) begin
        if (reset && l_out_valid && l_ready) begin
            if (exp_l.size() == 0) checkOutput("level_unexpected_index", l_out_index, 32'hFFFF_FFFF);
            else                   checkOutput("level_index", l_out_index, exp_l.pop_front());
        end
        if (reset && t_out_valid && t_ready) begin
            if (exp_t.size() == 0) checkOutput("toggle_unexpected_index", t_out_index, 32'hFFFF_FFFF);
            else                   checkOutput("toggle_index", t_out_index, exp_t.pop_front());
        end
    end

    initial begin
        reset = 1'b0;
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b1);
        t_valid = 8'h00; t_en = 1'b1; t_clear = 1'b0; t_ready = 1'b1;
        step(2);
        checkOutput("reset_out_valid", 32'(l_out_valid), 0);
        checkOutput("reset_count", 32'(l_count), 0);
        checkOutput("reset_all_covered", 32'(l_all), 0);
        checkOutput("reset_pending", 32'(l_pending), 0);
        checkOutput("reset_toggle_pending", 32'(t_pending), 0);

        // Toggle mode: first enabled cycle never reports, later a bit reports only once.
        reset = 1'b1; t_valid = 8'h10;
        step(1);
        exp_t.push_back(C + 4);
        t_valid = 8'h00;
        step(3);
        t_valid = 8'h10; step(1);
        t_valid = 8'h00; step(3);
        checkOutput("toggle_count_once", 32'(t_count), 1);
        checkOutput("toggle_all_covered", 32'(t_all), 0);
        exp_t.push_back(C + 0);
        t_valid = 8'h01; step(1);
        step(3);
        checkOutput("toggle_count_two", 32'(t_count), 2);

        // Level mode, ready high, 0x05 held three cycles.
        exp_l.push_back(C + 0);
        exp_l.push_back(C + 2);
        applyStimulus(8'h05, 1'b1, 1'b0, 1'b1); step(3);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b1); step(3);
        checkOutput("t1_count", 32'(l_count), 2);
        checkOutput("t1_pending", 32'(l_pending), 0);

        // All points at once under backpressure, then full drain.
        applyStimulus(8'h00, 1'b1, 1'b1, 1'b0); step(1);
        applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0); step(1);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0); step(3);
        checkOutput("t2_hold_valid", 32'(l_out_valid), 1);
        checkOutput("t2_hold_index", l_out_index, C + 0);
        checkOutput("t2_all_covered", 32'(l_all), 1);
        for (int i = 0; i < 8; i++) exp_l.push_back(C + i);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b1); step(8);
        checkOutput("t2_pending_after", 32'(l_pending), 0);
        checkOutput("t2_count", 32'(l_count), 8);

        // Clear while an index is in flight: it is dropped and clear-cycle hits are lost.
        applyStimulus(8'h00, 1'b1, 1'b1, 1'b0); step(1);
        applyStimulus(8'hF0, 1'b1, 1'b0, 1'b0); step(1);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0); step(1);
        checkOutput("t4_inflight_index", l_out_index, C + 4);
        applyStimulus(8'h01, 1'b1, 1'b1, 1'b0); step(1);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0); step(1);
        checkOutput("t4_out_valid_cleared", 32'(l_out_valid), 0);
        checkOutput("t4_count_cleared", 32'(l_count), 0);
        checkOutput("t4_pending_cleared", 32'(l_pending), 0);
        exp_l.push_back(C + 0);
        exp_l.push_back(C + 7);
        applyStimulus(8'h81, 1'b1, 1'b0, 1'b1); step(1);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b1); step(4);
        checkOutput("t4_count_rehit", 32'(l_count), 2);

        // New hit arriving while the output is stalled must not disturb it.
        applyStimulus(8'h00, 1'b1, 1'b1, 1'b0); step(1);
        applyStimulus(8'h08, 1'b1, 1'b0, 1'b0); step(1);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0); step(1);
        applyStimulus(8'h02, 1'b1, 1'b0, 1'b0); step(1);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0); step(1);
        checkOutput("t5_stall_valid", 32'(l_out_valid), 1);
        checkOutput("t5_stall_index", l_out_index, C + 3);
        exp_l.push_back(C + 3);
        exp_l.push_back(C + 1);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b1); step(3);
        checkOutput("t5_count", 32'(l_count), 2);
        checkOutput("t5_pending", 32'(l_pending), 0);

        // Disabled sampling ignores activity but keeps draining.
        applyStimulus(8'h00, 1'b1, 1'b1, 1'b0); step(1);
        applyStimulus(8'h03, 1'b1, 1'b0, 1'b0); step(1);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0); step(1);
        exp_l.push_back(C + 0);
        exp_l.push_back(C + 1);
        applyStimulus(8'hFF, 1'b0, 1'b0, 1'b1); step(4);
        checkOutput("t6_count", 32'(l_count), 2);
        checkOutput("t6_pending", 32'(l_pending), 0);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b1); step(2);
        checkOutput("t6_count_after_en", 32'(l_count), 2);

        for (int i = 0; i < 50 && (exp_l.size() != 0 || exp_t.size() != 0); i++) step(1);
        checkOutput("level_queue_drained", 32'(exp_l.size()), 0);
        checkOutput("toggle_queue_drained", 32'(exp_t.size()), 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
